// File: rtl/pc_addr_unit_if.sv
// Control/data bundle between the sequencer and pc_addr_unit.
// The master drives the controls and the slave (the address unit) drives the PC/IR/trace outputs.
interface pc_addr_unit_if #(
    parameter int PC_W = 9
);
    logic [1:0]        pc_sel;
    logic              load_pc;
    logic              load_ir;
    logic              load_addr;
    logic              addr_sel;
    logic [15:0]       datapath_out;
    logic [15:0]       mdata;
    logic              trace_rd;
    logic [PC_W-1:0]   PC;
    logic [PC_W-1:0]   mem_addr;
    logic [15:0]       ir;
    logic              trace_valid;
    logic [2*PC_W-1:0] trace_data;
    logic              trace_ovf;

    modport master (
        output pc_sel, load_pc, load_ir, load_addr, addr_sel, datapath_out, mdata, trace_rd,
        input  PC, mem_addr, ir, trace_valid, trace_data, trace_ovf
    );

    modport slave (
        input  pc_sel, load_pc, load_ir, load_addr, addr_sel, datapath_out, mdata, trace_rd,
        output PC, mem_addr, ir, trace_valid, trace_data, trace_ovf
    );
endinterface

// File: rtl/pc_addr_unit.sv
// Program counter, instruction register and data-address register with a memory-address mux.
// Optional branch-trace FIFO of {from_pc, to_pc} entries when PC_ADDR_TRACE_EN is defined.
module pc_addr_unit #(
    parameter int PC_W        = 9,
    parameter int TRACE_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_addr_unit_if.slave  bus
);

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] daddr_r;
    logic [15:0]     ir_r;
    logic [PC_W-1:0] next_pc_s;
    logic            push_s;

    function automatic logic [PC_W-1:0] sext_imm(input logic [7:0] imm);
        return {{(PC_W-8){imm[7]}}, imm};
    endfunction

    // Next-PC selection; all arithmetic wraps at PC_W bits.
    always_comb begin
        next_pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        case (bus.pc_sel)
            2'b00:   next_pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            2'b01:   next_pc_s = {PC_W{1'b0}};
            2'b10:   next_pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1} + sext_imm(ir_r[7:0]);
            2'b11:   next_pc_s = bus.datapath_out[PC_W-1:0];
            default: next_pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        endcase
    end

    assign push_s = bus.load_pc & bus.pc_sel[1];

    // PC, IR and data-address registers load independently from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= {PC_W{1'b0}};
            ir_r    <= 16'h0000;
            daddr_r <= {PC_W{1'b0}};
        end else begin
            if (bus.load_pc)   pc_r    <= next_pc_s;
            if (bus.load_ir)   ir_r    <= bus.mdata;
            if (bus.load_addr) daddr_r <= bus.datapath_out[PC_W-1:0];
        end
    end

    assign bus.PC       = pc_r;
    assign bus.ir       = ir_r;
    assign bus.mem_addr = bus.addr_sel ? pc_r : daddr_r;

`ifdef PC_ADDR_TRACE_EN
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TRACE_DEPTH);

    logic [2*PC_W-1:0] mem_r [TRACE_DEPTH];
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic              ovf_r;
    logic              full_s;
    logic              pop_s;
    logic [2*PC_W-1:0] head_s;
    logic              unused_bits_s;

    assign full_s = (count_r == FULL_CNT);
    assign pop_s  = bus.trace_rd & (count_r != {CW{1'b0}});

    // Entry storage; a reset edge discards the same-cycle push.
    always_ff @(posedge clk) begin
        if (push_s && !reset) mem_r[wr_ptr_r] <= {pc_r, next_pc_s};
    end

    // Pointers and occupancy; a push into a full FIFO without a pop drops the oldest entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s || full_s) rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            if (!pop_s && !full_s) count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            if (!pop_s && full_s) ovf_r <= 1'b1;
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            count_r  <= count_r - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Head presentation, zero when empty.
    always_comb begin
        head_s = {(2*PC_W){1'b0}};
        if (count_r != {CW{1'b0}}) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {(2*PC_W){1'b0}};
        end
    end

    assign bus.trace_valid = (count_r != {CW{1'b0}});
    assign bus.trace_data  = head_s;
    assign bus.trace_ovf   = ovf_r;
    assign unused_bits_s   = ^bus.datapath_out[15:PC_W];
`else
    logic unused_bits_s;

    assign bus.trace_valid = 1'b0;
    assign bus.trace_data  = {(2*PC_W){1'b0}};
    assign bus.trace_ovf   = 1'b0;
    assign unused_bits_s   = ^{bus.datapath_out[15:PC_W], bus.trace_rd, push_s, (TRACE_DEPTH > 0)};
`endif

endmodule

// File: tb/tb_pc_addr_unit.sv
// Directed self-checking bench for pc_addr_unit; trace expectations collapse to 0
// when PC_ADDR_TRACE_EN is not defined.
module tb_pc_addr_unit;

`ifdef PC_ADDR_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pc_addr_unit_if #(.PC_W(9)) bus ();

    pc_addr_unit #(.PC_W(9), .TRACE_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tx(input logic [31:0] v);
        return TR ? v : 32'h0;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        bus.pc_sel       = 2'b00;
        bus.load_pc      = 1'b0;
        bus.load_ir      = 1'b0;
        bus.load_addr    = 1'b0;
        bus.addr_sel     = 1'b1;
        bus.datapath_out = 16'h0000;
        bus.mdata        = 16'h0000;
        bus.trace_rd     = 1'b0;
        reset            = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_pc",    32'(bus.PC), 32'h000);
        chk("rst_ir",    32'(bus.ir), 32'h0000);
        chk("rst_maddr", 32'(bus.mem_addr), 32'h000);
        chk("rst_tv",    32'(bus.trace_valid), 32'h0);
        chk("rst_td",    32'(bus.trace_data), 32'h0);
        chk("rst_ovf",   32'(bus.trace_ovf), 32'h0);

        // Sequential fetch
        bus.load_pc = 1'b1;
        bus.pc_sel  = 2'b00;
        step(); chk("inc1", 32'(bus.PC), 32'h001); chk("inc1_ma", 32'(bus.mem_addr), 32'h001);
        step(); chk("inc2", 32'(bus.PC), 32'h002);
        step(); chk("inc3", 32'(bus.PC), 32'h003); chk("inc3_ma", 32'(bus.mem_addr), 32'h003);

        // IR / address loads with PC held
        bus.load_pc      = 1'b0;
        bus.load_ir      = 1'b1;
        bus.mdata        = 16'hD105;
        bus.load_addr    = 1'b1;
        bus.datapath_out = 16'h0042;
        step();
        bus.addr_sel = 1'b0;
        #1;
        chk("ld_ir",    32'(bus.ir), 32'hD105);
        chk("ld_daddr", 32'(bus.mem_addr), 32'h042);
        chk("pc_hold",  32'(bus.PC), 32'h003);
        chk("no_push",  32'(bus.trace_valid), 32'h0);

        // All three loads in one cycle; indirect jump pushes {0x003,0x010}
        bus.load_pc      = 1'b1;
        bus.pc_sel       = 2'b11;
        bus.datapath_out = 16'h0010;
        bus.mdata        = 16'h12FC;
        step();
        chk("co_pc",    32'(bus.PC), 32'h010);
        chk("co_ir",    32'(bus.ir), 32'h12FC);
        chk("co_daddr", 32'(bus.mem_addr), 32'h010);

        // Relative branch by -4: 0x010+1-4 = 0x00D
        bus.load_ir   = 1'b0;
        bus.load_addr = 1'b0;
        bus.pc_sel    = 2'b10;
        step();
        chk("br_pc",   32'(bus.PC), 32'h00D);
        chk("br_tv",   32'(bus.trace_valid), tx(32'h1));
        chk("br_head", 32'(bus.trace_data), tx(32'h0610));

        bus.load_pc  = 1'b0;
        bus.trace_rd = 1'b1;
        step();
        chk("pop1_head", 32'(bus.trace_data), tx(32'h200D));
        step();
        chk("pop2_tv", 32'(bus.trace_valid), 32'h0);
        chk("pop2_td", 32'(bus.trace_data), 32'h0);
        step();
        chk("pop_empty_tv", 32'(bus.trace_valid), 32'h0);
        bus.trace_rd = 1'b0;

        // Wrap and upper-bit truncation
        bus.load_pc      = 1'b1;
        bus.pc_sel       = 2'b11;
        bus.datapath_out = 16'h01FF;
        step(); chk("jmp_1ff", 32'(bus.PC), 32'h1FF);
        bus.pc_sel = 2'b00;
        step(); chk("wrap", 32'(bus.PC), 32'h000);
        bus.pc_sel       = 2'b11;
        bus.datapath_out = 16'hFE20;
        step();
        chk("trunc",      32'(bus.PC), 32'h020);
        chk("trunc_head", 32'(bus.trace_data), tx(32'h1BFF));
        bus.pc_sel = 2'b01;
        step(); chk("zero_sel", 32'(bus.PC), 32'h000);

        // Clean FIFO, then overflow with five branches (ir=0 -> PC+1)
        bus.load_pc = 1'b0;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_ir", 32'(bus.ir), 32'h0000);
        chk("rst2_tv", 32'(bus.trace_valid), 32'h0);
        bus.load_pc = 1'b1;
        bus.pc_sel  = 2'b10;
        for (int i = 0; i < 5; i++) step();
        chk("ovf_pc",   32'(bus.PC), 32'h005);
        chk("ovf_flag", 32'(bus.trace_ovf), tx(32'h1));
        chk("ovf_head", 32'(bus.trace_data), tx(32'h0202));

        // Push+pop when full: head advances, count stays 4
        bus.trace_rd = 1'b1;
        step();
        chk("pp_head", 32'(bus.trace_data), tx(32'h0403));
        chk("pp_ovf",  32'(bus.trace_ovf), tx(32'h1));
        bus.load_pc = 1'b0;
        step(); chk("drain1", 32'(bus.trace_data), tx(32'h0604));
        step(); chk("drain2", 32'(bus.trace_data), tx(32'h0805));
        step(); chk("drain3", 32'(bus.trace_data), tx(32'h0A06));
        step(); chk("drain4_tv", 32'(bus.trace_valid), 32'h0);
        chk("ovf_sticky", 32'(bus.trace_ovf), tx(32'h1));

        // Push+pop when empty keeps the new entry
        bus.load_pc = 1'b1;
        step();
        chk("ppe_pc",   32'(bus.PC), 32'h007);
        chk("ppe_tv",   32'(bus.trace_valid), tx(32'h1));
        chk("ppe_head", 32'(bus.trace_data), tx(32'h0C07));

        // Reset overrides a same-cycle jump/push
        bus.trace_rd     = 1'b0;
        bus.pc_sel       = 2'b11;
        bus.datapath_out = 16'h0155;
        bus.load_ir      = 1'b1;
        bus.mdata        = 16'hBEEF;
        reset            = 1'b1;
        step();
        reset         = 1'b0;
        bus.load_pc   = 1'b0;
        bus.load_ir   = 1'b0;
        bus.addr_sel  = 1'b1;
        #1;
        chk("rst3_pc",    32'(bus.PC), 32'h000);
        chk("rst3_ir",    32'(bus.ir), 32'h0000);
        chk("rst3_tv",    32'(bus.trace_valid), 32'h0);
        chk("rst3_ovf",   32'(bus.trace_ovf), 32'h0);
        chk("rst3_maddr", 32'(bus.mem_addr), 32'h000);
        bus.addr_sel = 1'b0;
        #1;
        chk("rst3_daddr", 32'(bus.mem_addr), 32'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_addr_unit.md
PC_ADDR_UNIT -- requirements
Module: pc_addr_unit

Interface
REQ-001 Parameter: PC_W, 9, width of PC, data address and memory address.
REQ-002 Parameter: TRACE_DEPTH, 4, branch-trace FIFO entries (power of 2, 2..16).
REQ-003 Clocking SHALL be one clock `clk`; reset SHALL be `reset`, synchronous, active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: pc_sel  in  2  next-PC source: 00 PC+1, 01 zero, 10 PC+1+sext(ir[7:0]), 11 datapath_out.
REQ-007 Port: load_pc  in  1  PC load enable.
REQ-008 Port: load_ir  in  1  instruction register load enable.
REQ-009 Port: load_addr  in  1  data address register load enable.
REQ-010 Port: addr_sel  in  1  mem_addr source: 1 PC, 0 data address.
REQ-011 Port: datapath_out  in  16  datapath result (register-indirect target, load/store address).
REQ-012 Port: mdata  in  16  memory read data.
REQ-013 Port: trace_rd  in  1  pop request for the trace FIFO.
REQ-014 Port: PC  out  PC_W  current program counter.
REQ-015 Port: mem_addr  out  PC_W  memory address, combinational mux of PC / data address.
REQ-016 Port: ir  out  16  instruction register.
REQ-017 Port: trace_valid  out  1  trace FIFO non-empty.
REQ-018 Port: trace_data  out  2*PC_W  FIFO head {from_pc, to_pc}.
REQ-019 Port: trace_ovf  out  1  sticky overflow flag.

Function
REQ-020 On a clk edge with load_pc=1, PC SHALL take the pc_sel-selected value; with load_pc=0, PC SHALL hold.
REQ-021 All PC arithmetic SHALL be modulo 2^PC_W; sext SHALL sign-extend ir[7:0] to PC_W bits; 0x1FF+1 SHALL wrap to 0x000.
REQ-022 pc_sel=11 SHALL load datapath_out[PC_W-1:0]; upper bits ignored.
REQ-023 load_ir=1 SHALL register mdata into ir at the edge; the value is visible the following cycle.
REQ-024 load_addr=1 SHALL register datapath_out[PC_W-1:0] into the data address register.
REQ-025 mem_addr SHALL be PC when addr_sel=1, data address when addr_sel=0, zero latency.
REQ-026 load_pc, load_ir and load_addr SHALL be independent; any combination in one cycle SHALL all take effect, each using pre-edge values.
REQ-027 A trace push SHALL occur on every edge with load_pc=1 and pc_sel in {10,11}, entry {old PC, new PC}; pc_sel 00/01 SHALL not push.
REQ-028 trace_valid SHALL be 1 iff the FIFO holds at least one entry; trace_data SHALL present the oldest entry, 0 when empty.
REQ-029 trace_rd=1 with trace_valid=1 SHALL pop the head at the edge; trace_rd when empty SHALL be ignored.
REQ-030 Push when full without pop SHALL discard the oldest entry, store the new one, and set trace_ovf.
REQ-031 Simultaneous push and pop when full SHALL pop then push, count unchanged, trace_ovf unchanged.
REQ-032 Simultaneous push and pop when empty SHALL leave the new entry in the FIFO (pop ignored).
REQ-033 trace_ovf SHALL remain 1 until reset.

Reset
REQ-034 reset=1 at an edge SHALL set PC, data address, ir to 0, empty the FIFO, clear trace_ovf, overriding all loads.
REQ-035 Reset asserted mid-sequence SHALL discard any same-cycle load or push; first post-reset fetch address SHALL be 0.

Configuration
REQ-036 Macro PC_ADDR_TRACE_EN: defined -> trace FIFO per REQ-027..033; undefined -> no FIFO storage, trace_valid, trace_data, trace_ovf tied 0, trace_rd ignored; PC/IR/address behaviour identical in both builds.

Verification
REQ-037 reset, load_pc=1 pc_sel=00 for 3 cycles -> PC 0,1,2,3; mem_addr=PC with addr_sel=1.
REQ-038 PC=0x010, ir[7:0]=0xFC, load_pc pc_sel=10 -> PC=0x00D; trace entry {0x010,0x00D}.
REQ-039 PC=0x1FF, pc_sel=00 load_pc -> PC=0x000; datapath_out=0xFE20, pc_sel=11 -> PC=0x020.
REQ-040 datapath_out=0x0042 load_addr, addr_sel=0 -> mem_addr=0x042; mdata=0xD105 load_ir -> ir=0xD105 next cycle.
REQ-041 5 taken branches with no pops (depth 4) -> trace_ovf=1, head = 2nd branch; push+pop when full -> count 4, head advances.
REQ-042 reset during load_pc pc_sel=11 with FIFO non-empty -> PC=0, trace_valid=0, trace_ovf=0.
